// File: rtl/priority_coder.sv
// priority_coder: registered lowest-set-bit encoder with a valid flag.
// A two-level tree finds the lowest non-empty group of GS bits and the
// lowest set bit inside every group, then joins the two indices.
module priority_coder #(
  parameter int unsigned N = 1024,
  parameter int unsigned M = 10
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] data_i,
  input  logic         enable_i,
  output logic [M-1:0] data_o,
  output logic         valid_o
);

  // Local index takes the lower half of the index bits (rounded up),
  // the group index takes the rest; at least one bit each internally.
  localparam int unsigned LW = (M + 1) / 2;
  localparam int unsigned GS = 1 << LW;
  localparam int unsigned NG = N / GS;
  localparam int unsigned GW = (M > LW) ? (M - LW) : 1;

  logic [NG-1:0]    grp_any;
  logic [NG*LW-1:0] grp_loc_flat;
  logic [GW-1:0]    grp_sel;
  logic [LW-1:0]    loc_sel;
  logic             any_c;
  logic [M-1:0]     idx_c;

  for (genvar g = 0; g < NG; g++) begin : g_grp
    logic [GS-1:0] slice;
    logic [LW-1:0] loc;

    assign slice   = data_i[g*GS +: GS];
    assign grp_any[g] = |slice;
    assign grp_loc_flat[g*LW +: LW] = loc;

    // Lowest set bit within this group; scanning downward lets the lowest win.
    always_comb begin
      loc = '0;
      for (int j = int'(GS) - 1; j >= 0; j--) begin
        if (slice[j]) loc = LW'(j);
      end
    end
  end

  // Lowest non-empty group.
  always_comb begin
    grp_sel = '0;
    for (int g = int'(NG) - 1; g >= 0; g--) begin
      if (grp_any[g]) grp_sel = GW'(g);
    end
  end

  assign any_c   = |grp_any;
  assign loc_sel = grp_loc_flat[grp_sel*LW +: LW];
  assign idx_c   = (M'(grp_sel) << LW) | M'(loc_sel);

  // Output registers: reset, disable and empty input all clear index and flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_o  <= '0;
      valid_o <= 1'b0;
    end else if (enable_i && any_c) begin
      data_o  <= idx_c;
      valid_o <= 1'b1;
    end else begin
      data_o  <= '0;
      valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_priority_coder.sv
// Directed bench for priority_coder (N=1024, M=10).
module tb_priority_coder;

  localparam int unsigned N = 1024;
  localparam int unsigned M = 10;

  logic         clk;
  logic         rst;
  logic [N-1:0] data;
  logic         en;
  logic [M-1:0] data_o;
  logic         valid_o;

  int n_vec;
  int n_bad;

  priority_coder #(.N(N), .M(M)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .data_i   (data),
    .enable_i (en),
    .data_o   (data_o),
    .valid_o  (valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare {valid_o, data_o} against the expected pair.
  task automatic check(input string tag, input logic [M:0] got, input logic [M:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got valid=%0b idx=%0d, expected valid=%0b idx=%0d",
               tag, got[M], got[M-1:0], exp[M], exp[M-1:0]);
    end
  endtask

  // Advance one edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [M:0] hit(input int unsigned k);
    return {1'b1, M'(k)};
  endfunction

  localparam logic [M:0] NONE = '0;

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst  = 1'b1;
    en   = 1'b1;
    data = '1;

    // Reset held two edges with all requests active.
    step(); check("reset0", {valid_o, data_o}, NONE);
    step(); check("reset1", {valid_o, data_o}, NONE);
    rst = 1'b0;
    step(); check("post_reset", {valid_o, data_o}, hit(0));

    // One-hot walk with a one-edge reset at bit 512.
    for (int k = 0; k < int'(N); k++) begin
      data = '0;
      data[k] = 1'b1;
      if (k == 512) begin
        rst = 1'b1;
        step(); check("walk_rst", {valid_o, data_o}, NONE);
        rst = 1'b0;
      end
      step(); check("walk", {valid_o, data_o}, hit(k));
    end
    check("walk_top", {valid_o, data_o}, {1'b1, 10'h3FF});

    // Multi-hot priority.
    data = '0;
    data[5] = 1'b1; data[300] = 1'b1; data[1023] = 1'b1;
    step(); check("multi_5", {valid_o, data_o}, hit(5));
    data[5] = 1'b0;
    step(); check("multi_300", {valid_o, data_o}, hit(300));
    data[300] = 1'b0;
    step(); check("multi_1023", {valid_o, data_o}, hit(1023));

    // Group boundaries: bit in group 1 beats bit in group 31.
    data = '0;
    data[32] = 1'b1; data[1000] = 1'b1;
    step(); check("grp_bound", {valid_o, data_o}, hit(32));
    data = '0;
    data[31] = 1'b1; data[32] = 1'b1;
    step(); check("grp_edge", {valid_o, data_o}, hit(31));

    // Empty input versus bit 0.
    data = '0;
    step(); check("empty", {valid_o, data_o}, NONE);
    data = 1;
    step(); check("bit0", {valid_o, data_o}, hit(0));

    // Enable gating.
    data = '0;
    data[77] = 1'b1;
    en = 1'b0;
    step(); check("en_off", {valid_o, data_o}, NONE);
    en = 1'b1;
    step(); check("en_on", {valid_o, data_o}, hit(77));
    en = 1'b0;
    step(); check("en_drop", {valid_o, data_o}, NONE);

    // Unknown data while disabled.
    data = 'x;
    step(); check("x_disabled", {valid_o, data_o}, NONE);

    // Reset overrides a live encode.
    data = '1;
    en = 1'b1;
    step(); check("all_ones", {valid_o, data_o}, hit(0));
    rst = 1'b1;
    step(); check("rst_mid", {valid_o, data_o}, NONE);
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
